// File: rtl/env_seq_pkg.sv
// Shared definitions for the envelope gate sequencer and the ADSR top level:
// FSM state encoding and default widths.
package env_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ON       = 2'd1,
    ST_OFF      = 2'd2,
    ST_WAIT_REL = 2'd3
  } seq_state_e;

  localparam int N_STEPS_DEF   = 8;
  localparam int NBIT_STEP_DEF = 3;
  localparam int NBIT_DUR_DEF  = 8;
  localparam int NBIT_DIV_DEF  = 16;

endpackage

// File: rtl/env_tick_div.sv
// Tempo prescaler: counts 0..tick_div and flags the terminal count as a tick.
// clr_i restarts the count so each sequencer phase begins on a full tick period.
module env_tick_div #(
  parameter int nbit_div = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic [nbit_div-1:0] tick_div_i,
  output logic                tick_o
);

  logic [nbit_div-1:0] cnt_q;
  logic [nbit_div-1:0] cnt_d;

  assign tick_o = (cnt_q == tick_div_i);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/env_gate_seq.sv
// Step sequencer driving the ADSR gate from a table of per-step on/off tick
// durations, with optional hold-off until the envelope finishes its release.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | stopped, gate low, step 0 selected
// ON       | gate high, dur_q counts remaining on-ticks of the step
// OFF      | gate low, dur_q counts remaining off-ticks (0 = single cycle)
// WAIT_REL | gate low, holding the next step until env_vout_i drops
module env_gate_seq
  import env_seq_pkg::*;
#(
  parameter int n_steps   = N_STEPS_DEF,
  parameter int nbit_step = NBIT_STEP_DEF,
  parameter int nbit_dur  = NBIT_DUR_DEF,
  parameter int nbit_div  = NBIT_DIV_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_i,
  input  logic                 wait_rel_i,
  input  logic [nbit_step-1:0] last_step_i,
  input  logic [nbit_div-1:0]  tick_div_i,
  input  logic                 wr_en_i,
  input  logic [nbit_step-1:0] wr_addr_i,
  input  logic [nbit_dur-1:0]  wr_on_i,
  input  logic [nbit_dur-1:0]  wr_off_i,
  input  logic                 env_vout_i,
  output logic                 gate_o,
  output logic [nbit_step-1:0] step_idx_o,
  output logic                 step_stb_o,
  output logic                 busy_o
);

  logic [nbit_dur-1:0]  tab_on_q  [n_steps];
  logic [nbit_dur-1:0]  tab_off_q [n_steps];

  seq_state_e           state_q;
  logic [nbit_dur-1:0]  dur_q;
  logic [nbit_dur-1:0]  off_q;
  logic [nbit_step-1:0] idx_q;
  logic                 gate_q;
  logic                 stb_q;

  logic                 tick;
  logic                 clr;
  logic                 dur_last;
  logic                 off_done;
  logic                 hold_rel;
  logic                 start;
  logic                 on_end;
  logic                 advance;
  logic [nbit_step-1:0] nxt_idx;
  logic [nbit_step-1:0] load_idx;

  env_tick_div #(
    .nbit_div (nbit_div)
  ) u_tick_div (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr),
    .tick_div_i (tick_div_i),
    .tick_o     (tick)
  );

  // A zero off-duration finishes without waiting for a tick, giving the
  // envelope exactly one low cycle.
  always_comb begin
    dur_last = (dur_q == nbit_dur'(1));
    off_done = (dur_q == '0) || (tick && dur_last);
    hold_rel = wait_rel_i && env_vout_i;
    nxt_idx  = (idx_q >= last_step_i) ? '0 : idx_q + 1'b1;
    start    = (state_q == ST_IDLE);
    on_end   = (state_q == ST_ON) && tick && dur_last;
    advance  = ((state_q == ST_OFF) && off_done && !hold_rel) ||
               ((state_q == ST_WAIT_REL) && !env_vout_i);
    load_idx = start ? '0 : nxt_idx;
    clr      = !run_i || start || advance || on_end;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dur_q   <= '0;
      off_q   <= '0;
      idx_q   <= '0;
      gate_q  <= 1'b0;
      stb_q   <= 1'b0;
      for (int i = 0; i < n_steps; i++) begin
        tab_on_q[i]  <= '0;
        tab_off_q[i] <= '0;
      end
    end else begin
      if (wr_en_i) begin
        tab_on_q[wr_addr_i]  <= wr_on_i;
        tab_off_q[wr_addr_i] <= wr_off_i;
      end
      stb_q <= 1'b0;
      if (!run_i) begin
        state_q <= ST_IDLE;
        dur_q   <= '0;
        off_q   <= '0;
        idx_q   <= '0;
        gate_q  <= 1'b0;
      end else if (start || advance) begin
        // Both durations are captured here so later table writes cannot
        // stretch or shorten the step already playing.
        idx_q <= load_idx;
        stb_q <= 1'b1;
        off_q <= tab_off_q[load_idx];
        if (tab_on_q[load_idx] != '0) begin
          state_q <= ST_ON;
          gate_q  <= 1'b1;
          dur_q   <= tab_on_q[load_idx];
        end else begin
          state_q <= ST_OFF;
          gate_q  <= 1'b0;
          dur_q   <= tab_off_q[load_idx];
        end
      end else begin
        case (state_q)
          ST_ON: begin
            if (on_end) begin
              state_q <= ST_OFF;
              gate_q  <= 1'b0;
              dur_q   <= off_q;
            end else if (tick) begin
              dur_q <= dur_q - 1'b1;
            end
          end
          ST_OFF: begin
            if (off_done) begin
              state_q <= ST_WAIT_REL;
            end else if (tick) begin
              dur_q <= dur_q - 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign gate_o     = gate_q;
  assign step_idx_o = idx_q;
  assign step_stb_o = stb_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_env_gate_seq.sv
// Bench for env_gate_seq: directed scenarios plus randomized traffic, checked
// every cycle against a cycle-schedule model of the sequencer.
module tb_env_gate_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        wait_rel;
  logic [2:0]  last_step;
  logic [15:0] tick_div;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_on;
  logic [7:0]  wr_off;
  logic        env_vout;
  logic        gate;
  logic [2:0]  step_idx;
  logic        stb;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  env_gate_seq dut (
    .clk         (clk),
    .rst         (rst),
    .run_i       (run),
    .wait_rel_i  (wait_rel),
    .last_step_i (last_step),
    .tick_div_i  (tick_div),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_on_i     (wr_on),
    .wr_off_i    (wr_off),
    .env_vout_i  (env_vout),
    .gate_o      (gate),
    .step_idx_o  (step_idx),
    .step_stb_o  (stb),
    .busy_o      (busy)
  );

  // Model: a step is a precomputed list of per-cycle gate levels.
  int m_on  [8];
  int m_off [8];
  bit m_busy, m_wait, m_gate, m_stb;
  int m_idx;
  bit sched[$];
  int cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (time %0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic bound_ok(input string tag, input int used, input int limit);
    n_checks++;
    assert (used < limit) else begin
      n_fail++;
      $error("FAIL %s observed=timeout after %0d cycles expected=event", tag, used);
    end
  endtask

  task automatic m_load(input int i);
    int period, n_hi, n_lo;
    period = int'(tick_div) + 1;
    n_hi   = m_on[i] * period;
    n_lo   = (m_off[i] == 0) ? 1 : m_off[i] * period;
    sched.delete();
    for (int k = 0; k < n_hi; k++) sched.push_back(1'b1);
    for (int k = 0; k < n_lo; k++) sched.push_back(1'b0);
    m_idx  = i;
    m_stb  = 1'b1;
    m_busy = 1'b1;
    m_wait = 1'b0;
    m_gate = sched[0];
  endtask

  task automatic model_edge();
    int nxt;
    m_stb = 1'b0;
    if (rst) begin
      m_busy = 0; m_wait = 0; m_gate = 0; m_idx = 0;
      sched.delete();
      for (int i = 0; i < 8; i++) begin m_on[i] = 0; m_off[i] = 0; end
    end else begin
      nxt = (m_idx >= int'(last_step)) ? 0 : m_idx + 1;
      if (!run) begin
        m_busy = 0; m_wait = 0; m_gate = 0; m_idx = 0;
        sched.delete();
      end else if (!m_busy) begin
        m_load(0);
      end else if (m_wait) begin
        if (!env_vout) m_load(nxt);
      end else begin
        void'(sched.pop_front());
        if (sched.size() == 0) begin
          if (wait_rel && env_vout) begin
            m_wait = 1'b1;
            m_gate = 1'b0;
          end else begin
            m_load(nxt);
          end
        end else begin
          m_gate = sched[0];
        end
      end
      if (wr_en) begin
        m_on[wr_addr]  = int'(wr_on);
        m_off[wr_addr] = int'(wr_off);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("gate", gate, m_gate);
    chk("step_idx", step_idx, m_idx);
    chk("step_stb", stb, m_stb);
    chk("busy", busy, m_busy);
  endtask

  task automatic write_step(input int a, input int on, input int off);
    wr_en = 1'b1; wr_addr = 3'(a); wr_on = 8'(on); wr_off = 8'(off);
    cycle();
    wr_en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=no finish expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hi, held, exp_idx;
    bit done;

    rst = 1; run = 0; wait_rel = 0; last_step = 0; tick_div = 0;
    wr_en = 0; wr_addr = 0; wr_on = 0; wr_off = 0; env_vout = 0;
    cyc = 0;
    cycle(); cycle();
    chk("rst_gate", gate, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    cycle();

    // Basic loop
    tick_div = 3; last_step = 1;
    write_step(0, 2, 1);
    write_step(1, 1, 2);
    run = 1; cyc = 0;
    for (int c = 1; c <= 28; c++) begin
      cycle();
      chk("basic_gate", gate, ((cyc <= 8) || (cyc >= 13 && cyc <= 16) || cyc >= 25) ? 1 : 0);
      chk("basic_stb", stb, (cyc == 1 || cyc == 13 || cyc == 25) ? 1 : 0);
    end

    // Rest step and zero-off
    run = 0; cycle();
    tick_div = 0;
    write_step(0, 0, 1);
    write_step(1, 1, 0);
    run = 1; cyc = 0;
    for (int c = 1; c <= 9; c++) begin
      cycle();
      chk("rest_gate", gate, (cyc % 3 == 2) ? 1 : 0);
      chk("rest_stb", stb, (cyc % 3 != 0) ? 1 : 0);
    end

    // Wait-release
    run = 0; cycle();
    tick_div = 1;
    write_step(0, 1, 1);
    write_step(1, 2, 1);
    wait_rel = 1; env_vout = 1; run = 1;
    n = 0;
    while (!m_wait && n < 100) begin cycle(); n++; end
    bound_ok("wr_reach", n, 100);
    held = m_idx;
    for (int k = 0; k < 20; k++) begin
      cycle();
      chk("wr_hold_gate", gate, 0);
      chk("wr_hold_idx", step_idx, held);
    end
    env_vout = 0;
    cycle();
    exp_idx = (held >= 1) ? 0 : held + 1;
    chk("wr_release_stb", stb, 1);
    chk("wr_release_idx", step_idx, exp_idx);
    wait_rel = 0;

    // Stop mid-note at step 3, then restart
    run = 0; cycle();
    for (int a = 0; a < 5; a++) write_step(a, 2, 2);
    last_step = 4; run = 1;
    n = 0;
    while (!(m_idx == 3 && m_gate) && n < 200) begin cycle(); n++; end
    bound_ok("stop_reach", n, 200);
    run = 0;
    cycle();
    chk("stop_gate", gate, 0);
    chk("stop_idx", step_idx, 0);
    chk("stop_busy", busy, 0);
    chk("stop_stb", stb, 0);
    run = 1;
    cycle();
    chk("restart_stb", stb, 1);
    chk("restart_idx", step_idx, 0);
    chk("restart_gate", gate, 1);

    // Live table write: the current on-phase keeps its length
    run = 0; cycle();
    run = 1;
    hi = 0; done = 0;
    for (int k = 0; k < 12; k++) begin
      if (k == 1) begin wr_en = 1; wr_addr = 0; wr_on = 5; wr_off = 1; end
      cycle();
      wr_en = 0;
      if (!done) begin
        if (gate) hi++;
        else done = 1;
      end
    end
    chk("live_cur_len", hi, 4);
    n = 0;
    while (!(m_stb && m_idx == 0) && n < 200) begin cycle(); n++; end
    bound_ok("live_revisit", n, 200);
    hi = gate ? 1 : 0; done = 0;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (!done) begin
        if (gate) hi++;
        else done = 1;
      end
    end
    chk("live_next_len", hi, 10);

    // Wrap when last_step drops below the playing step
    last_step = 7;
    for (int a = 5; a < 8; a++) write_step(a, 1, 1);
    n = 0;
    while (m_idx != 5 && n < 300) begin cycle(); n++; end
    bound_ok("wrap_reach", n, 300);
    last_step = 2;
    n = 0;
    do begin cycle(); n++; end while (!m_stb && n < 100);
    bound_ok("wrap_stb", n, 100);
    chk("wrap_idx", step_idx, 0);

    // Reset during OFF clears outputs and table
    n = 0;
    while (!(m_busy && !m_wait && !m_gate) && n < 100) begin cycle(); n++; end
    bound_ok("rstoff_reach", n, 100);
    rst = 1;
    cycle();
    chk("rstoff_gate", gate, 0);
    chk("rstoff_idx", step_idx, 0);
    chk("rstoff_stb", stb, 0);
    chk("rstoff_busy", busy, 0);
    rst = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("cleared_gate", gate, 0);
      chk("cleared_stb", stb, 1);
    end

    // Randomized traffic
    tick_div = 16'($urandom_range(0, 2));
    for (int a = 0; a < 8; a++) write_step(a, $urandom_range(0, 3), $urandom_range(0, 3));
    for (int k = 0; k < 700; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        run = ~run;
        if (!run) tick_div = 16'($urandom_range(0, 2));
      end
      if ($urandom_range(0, 29) == 0) last_step = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) wait_rel = ~wait_rel;
      if ($urandom_range(0, 5) == 0) env_vout = ~env_vout;
      if ($urandom_range(0, 7) == 0) begin
        wr_en = 1; wr_addr = 3'($urandom_range(0, 7));
        wr_on = 8'($urandom_range(0, 3)); wr_off = 8'($urandom_range(0, 3));
      end
      rst = ($urandom_range(0, 299) == 0);
      cycle();
      wr_en = 0; rst = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
